window_ring_buffer: RTL and testbench

WINDOW_RING_BUFFER -- requirements
Module: window_ring_buffer

---
 rtl/window_ring_pkg.sv | 19 +
 rtl/window_ring_mem.sv | 32 +++
 rtl/window_ring_buffer.sv | 171 +++++++++++++++++
 tb/tb_window_ring_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_ring_pkg.sv
// Shared defaults and FSM state type for the windowed per-channel ring buffer.
package window_ring_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SLOT_BITS = 10;
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_SHIFT     = 64;

  typedef enum logic {
    CLEAR,
    RUN
  } ring_state_t;

  // Channel select width; a single-channel build still carries one select bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_ring_mem.sv
// Simple dual-port storage: write port A, registered read-first port B, no reset
// so the array maps onto block RAM.
module window_ring_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int WORDS  = 2048
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [0:WORDS-1];
  logic [DATA_W-1:0] rd_data_reg;

  // Both ports sample the array before the write lands, giving read-first behaviour.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/window_ring_buffer.sv
// Per-channel sliding-window ring buffer: offsets, FSM, sweep and address arithmetic.
// Define WINDOW_RING_CLEAR_EN to zero every word after reset before ready rises.
module window_ring_buffer
  import window_ring_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       ready,
  input  logic                       wr_en,
  input  logic [ch_bits(NUM_CH)-1:0] wr_ch,
  input  logic [SLOT_BITS-1:0]       wr_index,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [ch_bits(NUM_CH)-1:0] rd_ch,
  input  logic [SLOT_BITS-1:0]       rd_index,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       shift_req,
  input  logic [ch_bits(NUM_CH)-1:0] shift_ch,
  output logic                       ch_err
);

  localparam int CH_W   = ch_bits(NUM_CH);
  localparam int ADDR_W = CH_W + SLOT_BITS;
  localparam int WORDS  = NUM_CH << SLOT_BITS;
  localparam logic [SLOT_BITS-1:0] SHIFT_SLOTS = SLOT_BITS'(SHIFT);

  ring_state_t       state_reg;
  logic              ready_reg;
  logic              rd_valid_reg;
  logic              data_live_reg;
  logic              ch_err_reg;

  logic [SLOT_BITS-1:0] off_reg [NUM_CH];
  logic [SLOT_BITS-1:0] wr_off, rd_off;
  logic [SLOT_BITS-1:0] wr_slot, rd_slot;

  logic              wr_ch_ok, rd_ch_ok, shift_ch_ok;
  logic              wr_ok, rd_ok, shift_ok, bad_req;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

`ifdef WINDOW_RING_CLEAR_EN
  localparam ring_state_t RESET_STATE = CLEAR;
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(WORDS - 1);
  logic [ADDR_W-1:0] sweep_reg;
`else
  localparam ring_state_t RESET_STATE = RUN;
`endif

  // Request qualification: every request is gated by ready, then by channel range.
  assign wr_ch_ok    = int'(wr_ch) < NUM_CH;
  assign rd_ch_ok    = int'(rd_ch) < NUM_CH;
  assign shift_ch_ok = int'(shift_ch) < NUM_CH;

  assign wr_ok    = ready_reg && wr_en && wr_ch_ok;
  assign rd_ok    = ready_reg && rd_en && rd_ch_ok;
  assign shift_ok = ready_reg && shift_req && shift_ch_ok;
  assign bad_req  = ready_reg && ((wr_en && !wr_ch_ok) ||
                                  (rd_en && !rd_ch_ok) ||
                                  (shift_req && !shift_ch_ok));

  // Offset lookup uses the registered (pre-shift) value for same-cycle accesses.
  always_comb begin
    wr_off = '0;
    rd_off = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(wr_ch) == c) wr_off = off_reg[c];
      if (int'(rd_ch) == c) rd_off = off_reg[c];
    end
  end

  // Slot arithmetic wraps in SLOT_BITS; channel sits above it so regions never overlap.
  assign wr_slot = wr_off + wr_index;
  assign rd_slot = rd_off + rd_index;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_off
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        off_reg[gi] <= '0;
      end else if (shift_ok && (int'(shift_ch) == gi)) begin
        off_reg[gi] <= off_reg[gi] - SHIFT_SLOTS;
      end
    end
  end

  always_comb begin
    mem_wr_en   = wr_ok;
    mem_wr_addr = {wr_ch, wr_slot};
    mem_wr_data = wr_data;
`ifdef WINDOW_RING_CLEAR_EN
    if (state_reg == CLEAR) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = sweep_reg;
      mem_wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RESET_STATE;
      ready_reg <= 1'b0;
`ifdef WINDOW_RING_CLEAR_EN
      sweep_reg <= '0;
`endif
    end else begin
      case (state_reg)
`ifdef WINDOW_RING_CLEAR_EN
        CLEAR: begin
          if (sweep_reg == SWEEP_LAST) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end else begin
            sweep_reg <= sweep_reg + 1'b1;
          end
        end
`endif
        default: begin
          state_reg <= RUN;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // The RAM output register cannot be reset, so rd_data is masked until a read lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_reg  <= 1'b0;
      data_live_reg <= 1'b0;
      ch_err_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= rd_ok;
      if (rd_ok) begin
        data_live_reg <= 1'b1;
      end
      if (bad_req) begin
        ch_err_reg <= 1'b1;
      end
    end
  end

  window_ring_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_en   (rd_ok),
    .rd_addr ({rd_ch, rd_slot}),
    .rd_data (mem_rd_data)
  );

  assign ready    = ready_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = data_live_reg ? mem_rd_data : '0;
  assign ch_err   = ch_err_reg;

endmodule

// File: tb/tb_window_ring_buffer.sv
// Self-checking bench for window_ring_buffer: vector table, corner sequences and a
// randomized run against a channel/offset array model.
module tb_window_ring_buffer;

  localparam int DATA_W    = 16;
  localparam int SLOT_BITS = 10;
  localparam int NUM_CH    = 3;
  localparam int SHIFT     = 64;
  localparam int DEPTH     = 1 << SLOT_BITS;
  localparam int WORDS     = NUM_CH * DEPTH;
`ifdef WINDOW_RING_CLEAR_EN
  localparam bit CLEAR_ON  = 1'b1;
  localparam int EXP_LAT   = WORDS;
`else
  localparam bit CLEAR_ON  = 1'b0;
  localparam int EXP_LAT   = 1;
`endif

  logic              clock;
  logic              reset;
  logic              ready;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [SLOT_BITS-1:0] wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [1:0]        rd_ch;
  logic [SLOT_BITS-1:0] rd_index;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              shift_req;
  logic [1:0]        shift_ch;
  logic              ch_err;

  window_ring_buffer #(
    .DATA_W    (DATA_W),
    .SLOT_BITS (SLOT_BITS),
    .NUM_CH    (NUM_CH),
    .SHIFT     (SHIFT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_ch     (rd_ch),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .shift_req (shift_req),
    .shift_ch  (shift_ch),
    .ch_err    (ch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: logical storage per channel plus a window offset per channel.
  logic [DATA_W-1:0] mem_m [NUM_CH][DEPTH];
  int                off_m [NUM_CH];
  logic              exp_v;
  logic [DATA_W-1:0] exp_d;
  logic              exp_err;

  typedef struct {
    logic              wr;
    int                wch;
    int                widx;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    int                rch;
    int                ridx;
    logic              sh;
    int                sch;
    logic              e_v;
    logic [DATA_W-1:0] e_d;
    logic              e_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_ch = 0; wr_index = 0; wr_data = 0;
    rd_en = 0; rd_ch = 0; rd_index = 0;
    shift_req = 0; shift_ch = 0;
  endtask

  task automatic model_zero();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < DEPTH; s++) mem_m[c][s] = '0;
  endtask

  // Drive one cycle of requests; the model predicts what the outputs show afterwards.
  task automatic apply(input logic wr, input int wch, input int widx, input logic [DATA_W-1:0] wdata,
                       input logic rd, input int rch, input int ridx, input logic sh, input int sch);
    exp_v = 1'b0;
    if (rd && rch < NUM_CH) begin
      exp_v = 1'b1;
      exp_d = mem_m[rch][(off_m[rch] + ridx) % DEPTH];
    end
    if ((wr && wch >= NUM_CH) || (rd && rch >= NUM_CH) || (sh && sch >= NUM_CH)) exp_err = 1'b1;
    if (wr && wch < NUM_CH) mem_m[wch][(off_m[wch] + widx) % DEPTH] = wdata;
    if (sh && sch < NUM_CH) off_m[sch] = (off_m[sch] - SHIFT + DEPTH) % DEPTH;
    wr_en = wr; wr_ch = 2'(wch); wr_index = SLOT_BITS'(widx); wr_data = wdata;
    rd_en = rd; rd_ch = 2'(rch); rd_index = SLOT_BITS'(ridx);
    shift_req = sh; shift_ch = 2'(sch);
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s_valid", tag), rd_valid, exp_v);
    check($sformatf("%s_data", tag), rd_data, exp_d);
    check($sformatf("%s_err", tag), ch_err, exp_err);
  endtask

  task automatic fill_zero();
    for (int a = 0; a < WORDS; a++) apply(1, a / DEPTH, a % DEPTH, '0, 0, 0, 0, 0, 0);
  endtask

  // Reset, optionally abort a run after abort_at cycles, then time the not-ready window
  // while holding requests that must all be ignored.
  task automatic do_reset(input bit ign_check, input int abort_at);
    int lat;
    bit saw_v;
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", ready, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ch_err", ch_err, 0);
    if (abort_at > 0) begin
      reset = 1'b0;
      repeat (abort_at) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort_ready", ready, 0);
    end
    wr_en = 1; wr_ch = 0; wr_index = 9; wr_data = 16'hDEAD;
    rd_en = 1; rd_ch = 1; rd_index = 0;
    shift_req = 1; shift_ch = 3;
    reset = 1'b0;
    lat = 0;
    saw_v = 0;
    for (int i = 1; i <= WORDS + 16; i++) begin
      @(posedge clock);
      #1;
      if (rd_valid) saw_v = 1;
      if (ready) begin
        lat = i;
        break;
      end
    end
    clear_inputs();
    check("ready_latency", lat, EXP_LAT);
    check("notready_rd_valid", saw_v, 0);
    @(posedge clock);
    #1;
    check("notready_ch_err", ch_err, 0);
    for (int c = 0; c < NUM_CH; c++) off_m[c] = 0;
    exp_d = '0;
    exp_v = 1'b0;
    exp_err = 1'b0;
    if (CLEAR_ON || ign_check) model_zero();
    if (CLEAR_ON || ign_check) begin
      apply(0, 0, 0, 0, 1, 0, 9, 0, 0);
      check_model("ignored_write");
      $display("reset: latency=%0d ignored-write read rd_data=%h", lat, rd_data);
    end
    if (!CLEAR_ON) begin
      fill_zero();
      model_zero();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wr, rd, sh;
    clear_inputs();
    reset = 1'b1;
    exp_err = 1'b0;
    exp_d = '0;
    exp_v = 1'b0;
    for (int c = 0; c < NUM_CH; c++) off_m[c] = 0;

    //          wr wch widx wdata      rd rch ridx sh sch  e_v e_d        e_err
    vecs[0]  = '{1, 0,    5, 16'hA5A5, 0, 0,    0, 0, 0,   0, 16'h0000, 0};
    vecs[1]  = '{0, 0,    0, 16'h0000, 1, 0,    5, 0, 0,   1, 16'hA5A5, 0};
    vecs[2]  = '{0, 0,    0, 16'h0000, 1, 1,    5, 0, 0,   1, 16'h0000, 0};
    vecs[3]  = '{0, 0,    0, 16'h0000, 0, 0,    0, 0, 0,   0, 16'h0000, 0};
    vecs[4]  = '{1, 0,    0, 16'h1234, 0, 0,    0, 0, 0,   0, 16'h0000, 0};
    vecs[5]  = '{0, 0,    0, 16'h0000, 0, 0,    0, 1, 0,   0, 16'h0000, 0};
    vecs[6]  = '{0, 0,    0, 16'h0000, 1, 0,   64, 0, 0,   1, 16'h1234, 0};
    vecs[7]  = '{1, 0,    7, 16'hBEEF, 1, 0,    7, 1, 0,   1, 16'h0000, 0};
    vecs[8]  = '{0, 0,    0, 16'h0000, 1, 0,   71, 0, 0,   1, 16'hBEEF, 0};
    vecs[9]  = '{0, 0,    0, 16'h0000, 1, 0,    7, 0, 0,   1, 16'h0000, 0};
    vecs[10] = '{1, 1, 1023, 16'h7777, 1, 1, 1023, 0, 0,   1, 16'h0000, 0};
    vecs[11] = '{0, 0,    0, 16'h0000, 1, 1, 1023, 0, 0,   1, 16'h7777, 0};
    vecs[12] = '{1, 2,    3, 16'h0C0C, 1, 2,    3, 0, 0,   1, 16'h0000, 0};
    vecs[13] = '{0, 0,    0, 16'h0000, 1, 2,    3, 0, 0,   1, 16'h0C0C, 0};
    vecs[14] = '{0, 0,    0, 16'h0000, 0, 0,    0, 0, 0,   0, 16'h0C0C, 0};

    do_reset(1'b1, 0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].wr, vecs[i].wch, vecs[i].widx, vecs[i].wdata,
            vecs[i].rd, vecs[i].rch, vecs[i].ridx, vecs[i].sh, vecs[i].sch);
      check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].e_v);
      check($sformatf("vec%0d_data", i), rd_data, vecs[i].e_d);
      check($sformatf("vec%0d_err", i), ch_err, vecs[i].e_err);
      $display("vec %0d: rd_valid=%0b rd_data=%h ch_err=%0b", i, rd_valid, rd_data, ch_err);
    end

    // Two shifts so far; fourteen more bring off[0] back round to zero.
    for (int i = 0; i < 14; i++) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 1, 0, 967, 0, 0);
    check("wrap16_data", rd_data, 16'hBEEF);
    check("wrap16_valid", rd_valid, 1);
    $display("wrap16: read ch0 idx 967 rd_data=%h", rd_data);
    apply(0, 0, 0, 0, 1, 1, 1023, 0, 0);
    check("ch1_untouched", rd_data, 16'h7777);
    $display("ch1 check: read ch1 idx 1023 rd_data=%h", rd_data);

    for (int i = 0; i < 400; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      sh = ($urandom_range(0, 7) == 0);
      apply(wr, $urandom_range(0, NUM_CH - 1), $urandom_range(0, DEPTH - 1), DATA_W'($urandom),
            rd, $urandom_range(0, NUM_CH - 1), $urandom_range(0, DEPTH - 1),
            sh, $urandom_range(0, NUM_CH - 1));
      check_model($sformatf("rnd%0d", i));
      $display("rnd %0d: rd_valid=%0b rd_data=%h", i, rd_valid, rd_data);
    end

    apply(1, 3, 3, 16'hFFFF, 1, 3, 3, 1, 3);
    check("badch_err", ch_err, 1);
    check("badch_valid", rd_valid, 0);
    $display("bad channel: ch_err=%0b rd_valid=%0b", ch_err, rd_valid);
    for (int c = 0; c < NUM_CH; c++) begin
      apply(0, 0, 0, 0, 1, c, 3, 0, 0);
      check_model($sformatf("badch_store%0d", c));
      $display("bad channel: read ch%0d idx 3 rd_data=%h", c, rd_data);
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("badch_sticky%0d", i), ch_err, 1);
    end

    do_reset(1'b0, 100);
    apply(0, 0, 0, 0, 1, 1, 1023, 0, 0);
    check("post_clear_data", rd_data, 16'h0000);
    check("post_clear_valid", rd_valid, 1);
    check("post_clear_err", ch_err, 0);
    $display("post reset: read ch1 idx 1023 rd_data=%h rd_valid=%0b", rd_data, rd_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
